saph_fpu_arb: RTL and testbench
===============================

# saph_fpu_arb

Shares one floating-point unit among `CHANNELS` GPU requesters. Each requester sees the standard FPU handshake: trigger, operands, mode, ready, result strobe, result. The block round-robin arbitrates requests onto the single FPU port. It tracks outstanding requests in an in-order tag FIFO of depth `DEPTH` and steers each FPU result strobe back to the channel that issued it. It sits between the shader-core FPU ports and the FPU, and supports any in-order FPU latency of one cycle or more.

## Interface
Parameters:
- `CHANNELS`, 4: number of requester channels, ≥1.
- `DEPTH`, 4: maximum outstanding FPU operations, ≥1, power of two.
- `FLOAT_W`, 32: operand/result width (matches `float`).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `up_trig`  in  CHANNELS  per-channel request.
- `up_lhs`, `up_rhs`  in  CHANNELS×FLOAT_W  per-channel operands.
- `up_mode`  in  CHANNELS×2  per-channel FPU mode.
- `up_ready`  out  CHANNELS  one-hot grant: request accepted this cycle.
- `up_q_trig`  out  CHANNELS  one-hot result strobe.
- `up_q_res`  out  FLOAT_W  result, broadcast to all channels.
- `fpu_trig`  out  1  FPU trigger.
- `fpu_lhs`, `fpu_rhs`  out  FLOAT_W  FPU operands.
- `fpu_mode`  out  2  FPU mode.
- `fpu_ready`  in  1  FPU can accept.
- `fpu_q_trig`  in  1  FPU result valid.
- `fpu_q_res`  in  FLOAT_W  FPU result.
- `outstanding`  out  $clog2(DEPTH+1)  occupancy of tag FIFO.
- `err_orphan`  out  1  sticky: result arrived with empty tag FIFO.

## Operation
- Handshake: a request on channel i transfers when `up_trig[i] && up_ready[i]`. The requester holds trig, operands and mode stable until then. `up_trig` must not depend combinationally on `up_ready`.
- `can_issue = fpu_ready && (outstanding < DEPTH || fpu_q_trig)`. Pop and push in the same cycle at full is legal.
- Grant: if `can_issue`, grant the first asserted `up_trig` searching from `rr_ptr` upward with wrap. Otherwise no grant.
- On a grant to channel g:
  - `up_ready = 1<<g`, `fpu_trig = 1`.
  - `fpu_lhs/rhs/mode` = channel g's fields.
  - Push g into the tag FIFO.
  - `rr_ptr <= (g+1) mod CHANNELS`.
- With no grant, `fpu_trig = 0`, operand outputs are don't-care (implementation drives channel `rr_ptr`), and `rr_ptr` holds.
- Result: when `fpu_q_trig` and the FIFO is non-empty:
  - `up_q_trig = 1<<head`.
  - Pop the FIFO.
  - `up_q_res = fpu_q_res` (always passed through combinationally).
- Orphan: `fpu_q_trig` with an empty FIFO drives `up_q_trig = 0` and sets `err_orphan`. It stays set until reset.
- Simultaneous push and pop: occupancy is unchanged and both take effect. A new tag is never the one popped in the same cycle, because FPU latency is ≥1.
- FIFO pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is a separate counter, 0..DEPTH.

## Timing
- Grant and FPU dispatch are combinational from `up_trig`/`fpu_ready`/`outstanding`, with zero added latency.
- Result steering is combinational from `fpu_q_trig`, with zero added latency.
- End-to-end: `up_q_trig[i]` asserts in the cycle the FPU's `q_trig` for that operation asserts.
- State: `rr_ptr`, FIFO storage/pointers, `outstanding`, `err_orphan`.
- Reset values, asynchronous:
  - `rr_ptr=0`, FIFO empty, `outstanding=0`, `err_orphan=0`.
  - So `up_ready=0` and `up_q_trig=0` while no trig/q_trig is present.
- Reset mid-operation discards all in-flight tags. Any FPU result arriving after reset is an orphan. The FPU is reset from the same `rst`, so this does not occur in normal use.
- `DEPTH=1`: at most one operation in flight. A back-to-back issue is possible only in the cycle the previous result returns.

## Test plan
- Single request, ch2 only, FPU latency 3: `up_ready=0100` in cycle 0, `fpu_lhs=ch2 lhs`. Three cycles later `up_q_trig=0100` and `up_q_res=fpu_q_res`. `outstanding` goes 1,1,1,0.
- All four channels hold trig, `fpu_ready=1`, DEPTH=8: grants 0,1,2,3,0,… on consecutive cycles. Results return in the same channel order.
- DEPTH=2, FPU latency 4, continuous requests: two grants, then `up_ready=0` for two cycles. A grant resumes in the same cycle the first `fpu_q_trig` asserts, and `outstanding` stays at 2.
- `fpu_ready=0` for 5 cycles with ch1 trig: no grant and `rr_ptr` is unchanged. The grant to ch1 lands in the first cycle `fpu_ready=1`.
- `fpu_q_trig=1` with empty FIFO: `up_q_trig=0` and `err_orphan` becomes 1 and stays 1. It clears only on `rst`.
- Assert `rst` with 3 operations outstanding: `outstanding=0`, `rr_ptr=0`, `err_orphan=0` immediately (asynchronously). The next grant goes to the lowest requesting channel.

Source files
------------

// File: rtl/saph_fpu_arb.sv
// Round-robin share of one FPU among CHANNELS requesters, with an in-order tag FIFO steering results back.
// Latency: grant/dispatch and result steering are combinational, zero added cycles.
// Backpressure: no grant while the FPU is not ready or DEPTH ops are in flight (unless one retires this cycle).

module saph_fpu_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  output logic [W-1:0]     head_dat,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally for power-of-two depths; a single entry never moves.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (DEPTH == 1) return '0;
    return p + 1'b1;
  endfunction

  assign head_dat = mem[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module saph_fpu_arb #(
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 4,
  parameter int FLOAT_W  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           up_trig,
  input  logic [CHANNELS*FLOAT_W-1:0]   up_lhs,
  input  logic [CHANNELS*FLOAT_W-1:0]   up_rhs,
  input  logic [CHANNELS*2-1:0]         up_mode,
  output logic [CHANNELS-1:0]           up_ready,
  output logic [CHANNELS-1:0]           up_q_trig,
  output logic [FLOAT_W-1:0]            up_q_res,
  output logic                          fpu_trig,
  output logic [FLOAT_W-1:0]            fpu_lhs,
  output logic [FLOAT_W-1:0]            fpu_rhs,
  output logic [1:0]                    fpu_mode,
  input  logic                          fpu_ready,
  input  logic                          fpu_q_trig,
  input  logic [FLOAT_W-1:0]            fpu_q_res,
  output logic [$clog2(DEPTH+1)-1:0]    outstanding,
  output logic                          err_orphan
);
  localparam int TAG_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [TAG_W-1:0] rr_ptr;
  logic [TAG_W-1:0] grant_idx;
  logic             grant_vld;
  logic             can_issue;
  logic [TAG_W:0]   rr_sum;
  logic [TAG_W-1:0] rr_cand;

  logic [TAG_W-1:0] head_tag;
  logic             tag_empty;
  logic             tag_full;
  logic             res_vld;

  // A full FIFO still admits a push when the head retires in the same cycle.
  assign can_issue = fpu_ready && (!tag_full || fpu_q_trig);
  assign res_vld   = fpu_q_trig && !tag_empty;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_ptr;
    rr_sum    = '0;
    rr_cand   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      rr_sum = {1'b0, rr_ptr} + (TAG_W+1)'(k);
      if (rr_sum >= (TAG_W+1)'(CHANNELS)) rr_sum = rr_sum - (TAG_W+1)'(CHANNELS);
      rr_cand = rr_sum[TAG_W-1:0];
      if (can_issue && !grant_vld && up_trig[rr_cand]) begin
        grant_vld = 1'b1;
        grant_idx = rr_cand;
      end
    end
  end

  // With no grant the mux still selects rr_ptr's channel; fpu_trig qualifies it.
  always_comb begin
    fpu_lhs  = '0;
    fpu_rhs  = '0;
    fpu_mode = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_idx == TAG_W'(i)) begin
        fpu_lhs  = up_lhs[i*FLOAT_W +: FLOAT_W];
        fpu_rhs  = up_rhs[i*FLOAT_W +: FLOAT_W];
        fpu_mode = up_mode[i*2 +: 2];
      end
    end
  end

  always_comb begin
    up_ready  = '0;
    up_q_trig = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      up_ready[i]  = grant_vld && (grant_idx == TAG_W'(i));
      up_q_trig[i] = res_vld && (head_tag == TAG_W'(i));
    end
  end

  assign fpu_trig = grant_vld;
  assign up_q_res = fpu_q_res;

  saph_fpu_fifo #(
    .W     (TAG_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (grant_vld),
    .push_dat (grant_idx),
    .pop      (res_vld),
    .head_dat (head_tag),
    .count    (outstanding),
    .empty    (tag_empty),
    .full     (tag_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (grant_vld)
        rr_ptr <= (grant_idx == TAG_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
      if (fpu_q_trig && tag_empty)
        err_orphan <= 1'b1;
    end
  end
endmodule

// File: tb/tb_saph_fpu_arb.sv
// Directed bench for saph_fpu_arb: a latency-programmable FPU model feeds a result scoreboard
// checked by an independent monitor; the driver checks grants, dispatch and occupancy.
module tb_saph_fpu_arb;
  localparam int CH = 4;
  localparam int DP = 4;
  localparam int FW = 32;
  localparam int CW = $clog2(DP + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [CH-1:0]     up_trig;
  logic [CH*FW-1:0]  up_lhs, up_rhs;
  logic [CH*2-1:0]   up_mode;
  logic [CH-1:0]     up_ready, up_q_trig;
  logic [FW-1:0]     up_q_res;
  logic              fpu_trig;
  logic [FW-1:0]     fpu_lhs, fpu_rhs;
  logic [1:0]        fpu_mode;
  logic              fpu_ready, fpu_q_trig;
  logic [FW-1:0]     fpu_q_res;
  logic [CW-1:0]     outstanding;
  logic              err_orphan;

  typedef struct {int ch; logic [FW-1:0] res;} exp_t;
  typedef struct {int due; logic [FW-1:0] res;} fpu_t;
  exp_t sb[$];
  fpu_t pipe[$];
  exp_t mon_e;

  logic [FW-1:0] lhs_t [CH];
  logic [FW-1:0] rhs_t [CH];
  logic [1:0]    mode_t[CH];

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int lat = 3;

  always #5 clk = ~clk;

  saph_fpu_arb #(.CHANNELS(CH), .DEPTH(DP), .FLOAT_W(FW)) dut (
    .clk(clk), .rst(rst), .up_trig(up_trig), .up_lhs(up_lhs), .up_rhs(up_rhs),
    .up_mode(up_mode), .up_ready(up_ready), .up_q_trig(up_q_trig), .up_q_res(up_q_res),
    .fpu_trig(fpu_trig), .fpu_lhs(fpu_lhs), .fpu_rhs(fpu_rhs), .fpu_mode(fpu_mode),
    .fpu_ready(fpu_ready), .fpu_q_trig(fpu_q_trig), .fpu_q_res(fpu_q_res),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  function automatic logic [FW-1:0] fmodel(input logic [FW-1:0] l, input logic [FW-1:0] r,
                                           input logic [1:0] m);
    return l + r + {30'b0, m};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock of stimulus: check this cycle's grant, then advance the FPU model.
  task automatic cycle(input logic [CH-1:0] er, input int eo);
    @(negedge clk);
    chk("up_ready", up_ready, er);
    chk("fpu_trig", fpu_trig, |er);
    if (eo >= 0) chk("outstanding", outstanding, eo);
    for (int i = 0; i < CH; i++) begin
      if (er[i]) begin
        chk("fpu_lhs", fpu_lhs, lhs_t[i]);
        chk("fpu_mode", fpu_mode, mode_t[i]);
        sb.push_back('{i, fmodel(lhs_t[i], rhs_t[i], mode_t[i])});
      end
    end
    if (fpu_trig && fpu_ready)
      pipe.push_back('{cyc + lat, fmodel(fpu_lhs, fpu_rhs, fpu_mode)});
    @(posedge clk);
    #1;
    cyc++;
    if (pipe.size() > 0 && pipe[0].due == cyc) begin
      fpu_q_trig = 1'b1;
      fpu_q_res  = pipe[0].res;
      void'(pipe.pop_front());
    end else begin
      fpu_q_trig = 1'b0;
      fpu_q_res  = '0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (fpu_q_trig) begin
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("q_strobe", up_q_trig, 64'(1) << mon_e.ch);
          chk("q_res", up_q_res, mon_e.res);
        end else begin
          chk("orphan_strobe", up_q_trig, 0);
        end
      end else if (up_q_trig != '0) begin
        chk("spurious_strobe", up_q_trig, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CH-1:0] t2 [8];
    logic [CH-1:0] t3 [10];
    int o2 [8];
    int o3 [10];
    t2 = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    o2 = '{0, 1, 2, 2, 2, 2, 2, 2};
    t3 = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000,
           4'b1000, 4'b0001, 4'b0010, 4'b0100};
    o3 = '{0, 1, 2, 3, 4, 4, 4, 4, 4, 4};

    for (int i = 0; i < CH; i++) begin
      lhs_t[i]  = 32'h3f80_0000 + i * 32'h0001_0101;
      rhs_t[i]  = 32'h4000_0000 ^ (i << 4);
      mode_t[i] = 2'(i);
      up_lhs[i*FW +: FW] = lhs_t[i];
      up_rhs[i*FW +: FW] = rhs_t[i];
      up_mode[i*2 +: 2]  = mode_t[i];
    end
    rst = 1'b1; up_trig = '0; fpu_ready = 1'b1; fpu_q_trig = 1'b0; fpu_q_res = '0;
    #12;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    chk("reset_err_orphan", err_orphan, 0);
    chk("reset_q_trig", up_q_trig, 0);
    cycle(4'b0000, 0);

    // Single request on ch2, latency 3
    lat = 3; up_trig = 4'b0100;
    cycle(4'b0100, 0);
    up_trig = '0;
    cycle(4'b0000, 1); cycle(4'b0000, 1); cycle(4'b0000, 1); cycle(4'b0000, 0);

    // All channels requesting, latency 2: rotation from rr_ptr=3
    lat = 2; up_trig = 4'b1111;
    for (int k = 0; k < 8; k++) cycle(t2[k], o2[k]);
    up_trig = '0;
    cycle(4'b0000, 2); cycle(4'b0000, 1); cycle(4'b0000, 0);

    // Fill to DEPTH with latency 6: stall, then issue alongside each retirement
    lat = 6; up_trig = 4'b1111;
    for (int k = 0; k < 10; k++) cycle(t3[k], o3[k]);
    up_trig = '0;
    repeat (6) cycle(4'b0000, -1);
    cycle(4'b0000, 0);

    // FPU not ready: hold, then grant ch1 on the first ready cycle
    lat = 2; fpu_ready = 1'b0; up_trig = 4'b0010;
    repeat (5) cycle(4'b0000, 0);
    fpu_ready = 1'b1;
    cycle(4'b0010, 0);
    up_trig = 4'b0110;
    cycle(4'b0100, 1);
    up_trig = '0;
    cycle(4'b0000, 2); cycle(4'b0000, 1); cycle(4'b0000, 0);

    // Orphan result sets a sticky error
    chk("err_before_orphan", err_orphan, 0);
    fpu_q_trig = 1'b1; fpu_q_res = 32'hdead_beef;
    cycle(4'b0000, 0);
    chk("err_orphan_set", err_orphan, 1);
    cycle(4'b0000, 0); cycle(4'b0000, 0);
    chk("err_orphan_sticky", err_orphan, 1);

    // Asynchronous reset with three operations in flight
    lat = 6; up_trig = 4'b1111;
    cycle(4'b1000, 0); cycle(4'b0001, 1); cycle(4'b0010, 2);
    up_trig = '0;
    cycle(4'b0000, 3);
    rst = 1'b1; fpu_q_trig = 1'b0; fpu_q_res = '0;
    #1;
    chk("async_rst_outstanding", outstanding, 0);
    chk("async_rst_err_orphan", err_orphan, 0);
    chk("async_rst_up_ready", up_ready, 0);
    sb.delete(); pipe.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1; cyc++;
    lat = 3; up_trig = 4'b1010;
    cycle(4'b0010, 0);
    up_trig = '0;
    cycle(4'b0000, 1); cycle(4'b0000, 1); cycle(4'b0000, 1); cycle(4'b0000, 0);

    chk("scoreboard_drained", sb.size(), 0);
    chk("fpu_pipe_drained", pipe.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
